// File: rtl/ftdi_uart_rx.sv
// 8N1 UART receiver for the FTDI host-to-FPGA line.
// Bytes are held in a ready/ack register. Framing and overrun errors are flagged.
module ftdi_uart_rx #(
    parameter int FREQUENCY = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       FTDI_TX,
    output logic [7:0] data,
    output logic       data_ready,
    input  logic       data_ack,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy,
    output logic [1:0] state_test
);

    localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [1:0]       sync_fill;
    logic             armed;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            sync_fill     <= 2'b00;
            armed         <= 1'b0;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            data          <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rx_m          <= FTDI_TX;
            rx_s          <= rx_m;
            sync_fill     <= {sync_fill[0], 1'b1};
            framing_error <= 1'b0;
            if (data_ack)
                data_ready <= 1'b0;

            case (state)
                IDLE: begin
                    // The synchronizer resets to 1; arm only once it carries the real line.
                    if (rx_s && sync_fill[1])
                        armed <= 1'b1;
                    if (armed && !rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_s, shreg[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (rx_s) begin
                            // A same-cycle ack frees the register for the new byte.
                            if (!data_ready || data_ack) begin
                                data       <= shreg;
                                data_ready <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                            armed         <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign state_test = state;

endmodule

// File: tb/tb_ftdi_uart_rx.sv
// Directed bench for ftdi_uart_rx at 16 clk/bit. A monitor logs received bytes,
// state changes and error pulses. The main sequence checks them against a scoreboard.
module tb_ftdi_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ftdi_tx;
    logic       data_ack;
    logic [7:0] data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun;
    logic       busy;
    logic [1:0] state_test;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [1:0] st_log[$];
    int got_rd   = 0;
    int cyc      = 0;
    int t_start  = 0;
    int rise_cyc = 0;
    int fe_cnt   = 0;
    int rise_cnt = 0;
    int ack_req  = 0;
    int ack_done = 0;
    bit auto_ack = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ftdi_uart_rx #(
        .FREQUENCY(1_600_000),
        .BAUD_RATE(100_000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .FTDI_TX(ftdi_tx),
        .data(data),
        .data_ready(data_ready),
        .data_ack(data_ack),
        .framing_error(framing_error),
        .overrun(overrun),
        .busy(busy),
        .state_test(state_test)
    );

    initial begin
        logic       pr;
        logic [1:0] ps;
        data_ack = 1'b0;
        pr = 1'b0;
        ps = 2'd0;
        forever begin
            @(negedge clk);
            data_ack = 1'b0;
            if (framing_error === 1'b1) fe_cnt++;
            if (state_test !== ps) st_log.push_back(state_test);
            ps = state_test;
            if (data_ready === 1'b1 && pr !== 1'b1) begin
                rise_cnt++;
                rise_cyc = cyc;
                got_q.push_back(data);
            end
            if (data_ready === 1'b1 && (auto_ack || ack_req != ack_done)) begin
                data_ack = 1'b1;
                if (ack_req != ack_done) ack_done++;
            end
            pr = data_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        ftdi_tx = v;
        tick(C);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input bit push);
        if (push) exp_q.push_back(b);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic drain();
        int n = 0;
        while ((got_q.size() - got_rd) < exp_q.size() && n < 40 * C) begin
            tick(1);
            n++;
        end
        chk("byte_count", got_q.size() - got_rd, exp_q.size());
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            chk("byte_value", 32'(got_q[got_rd]), 32'(exp_q.pop_front()));
            got_rd++;
        end
        exp_q.delete();
    endtask

    function automatic logic [1:0] st_at(input int idx);
        return (idx < st_log.size()) ? st_log[idx] : 2'bxx;
    endfunction

    initial begin
        int base;
        int fe0;
        int r0;
        int lat;
        logic [1:0] seq [4];
        seq = '{2'd1, 2'd2, 2'd3, 2'd0};

        reset   = 1'b1;
        ftdi_tx = 1'b1;
        tick(4);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_ferr", 32'(framing_error), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state_test), 32'd0);
        reset = 1'b0;
        tick(4);

        // Single frame: value, latency, state walk
        base = st_log.size();
        fe0  = fe_cnt;
        send(8'h4A, 1'b1, 1'b1);
        tick(C);
        drain();
        lat = rise_cyc - t_start;
        chk("latency_window", 32'(lat >= (19 * C / 2 - 3) && lat <= (19 * C / 2 + 3)), 32'd1);
        chk("state_seq_len", st_log.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("state_seq", 32'(st_at(base + i)), 32'(seq[i]));
        chk("ferr_none_4a", fe_cnt - fe0, 0);

        // Back-to-back frames with no idle gap
        r0 = rise_cnt;
        send(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1);
        tick(2 * C);
        drain();
        chk("b2b_rises", rise_cnt - r0, 2);
        chk("b2b_overrun", 32'(overrun), 32'd0);

        // Unacknowledged byte followed by another good frame
        auto_ack = 1'b0;
        send(8'h55, 1'b1, 1'b1);
        send(8'hA3, 1'b1, 1'b0);
        tick(2 * C);
        drain();
        chk("ovr_data", 32'(data), 32'h55);
        chk("ovr_ready", 32'(data_ready), 32'd1);
        chk("ovr_flag", 32'(overrun), 32'd1);

        // Short low glitch on an idle line
        base = st_log.size();
        fe0  = fe_cnt;
        ftdi_tx = 1'b0;
        tick(4);
        ftdi_tx = 1'b1;
        tick(3 * C);
        chk("glitch_seq_len", st_log.size() - base, 2);
        chk("glitch_start", 32'(st_at(base)), 32'd1);
        chk("glitch_idle", 32'(st_at(base + 1)), 32'd0);
        chk("glitch_data", 32'(data), 32'h55);
        chk("glitch_ready", 32'(data_ready), 32'd1);
        chk("glitch_ferr", fe_cnt - fe0, 0);

        ack_req++;
        tick(3);
        chk("ack_clears", 32'(data_ready), 32'd0);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        auto_ack = 1'b1;

        // Framing error, long break, then a good frame
        fe0 = fe_cnt;
        r0  = rise_cnt;
        send(8'h3C, 1'b0, 1'b0);
        ftdi_tx = 1'b0;
        tick(20 * C);
        ftdi_tx = 1'b1;
        tick(2 * C);
        send(8'h81, 1'b1, 1'b1);
        tick(C);
        drain();
        chk("break_ferr_pulses", fe_cnt - fe0, 1);
        chk("break_rises", rise_cnt - r0, 1);
        chk("break_data", 32'(data), 32'h81);

        // Reset in the middle of bit 4 of a 0x0F frame
        r0 = rise_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        ftdi_tx = 1'b0;
        tick(C / 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(C / 2 - 1);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        tick(2 * C);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_ready", 32'(data_ready), 32'd0);
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_rises", rise_cnt - r0, 0);
        chk("midrst_busy", 32'(busy), 32'd0);

        fe0 = fe_cnt;
        send(8'h12, 1'b1, 1'b1);
        tick(C);
        drain();
        chk("after_rst_data", 32'(data), 32'h12);
        chk("after_rst_ferr", fe_cnt - fe0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
